// File: rtl/dllp_extractor.sv
// Extracts 6-byte DLLPs from a per-lane marked 64-lane receive stream and packs
// completed DLLPs into registered per-beat output slots; framing errors pulse dllp_err.
//
// state     | meaning
// S_IDLE    | waiting for a valid SDP byte
// S_COLLECT | SDP seen; cnt payload bytes held in partial, END expected once cnt=6
module dllp_extractor #(
  parameter int LANES = 64,
  parameter int SLOTS = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [8*LANES-1:0]     Data_in,
  input  logic [LANES-1:0]       valid_d,
  input  logic [LANES-1:0]       dlpstart,
  input  logic [LANES-1:0]       dlpend,
  input  logic [LANES-1:0]       tlpstart,
  output logic [48*SLOTS-1:0]    dllp_data,
  output logic [SLOTS-1:0]       dllp_valid,
  output logic                   dllp_err
);

  localparam int SW = $clog2(SLOTS + 1);

  typedef enum logic {S_IDLE, S_COLLECT} state_t;

  state_t              state_q, state_n, st;
  logic [2:0]          cnt_q, cnt_n, cnt;
  logic [47:0]         partial_q, partial_n, part;
  logic [SW-1:0]       slot;
  logic [7:0]          lane_byte;
  logic [48*SLOTS-1:0] data_n;
  logic [SLOTS-1:0]    valid_n;
  logic                err_n;

  // Lane-by-lane unrolled scan; st/cnt/part ripple from lane 0 to LANES-1 and
  // the final values become the state carried into the next beat.
  always_comb begin
    st        = state_q;
    cnt       = cnt_q;
    part      = partial_q;
    slot      = '0;
    lane_byte = '0;
    data_n    = '0;
    valid_n   = '0;
    err_n     = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      lane_byte = Data_in[8*i +: 8];
      if (valid_d[i]) begin
        case (st)
          S_IDLE: begin
            if (dlpstart[i]) begin
              st   = S_COLLECT;
              cnt  = '0;
              part = '0;
            end else if (dlpend[i]) begin
              err_n = 1'b1;
            end
          end
          S_COLLECT: begin
            if (cnt != 3'd6) begin
              if (dlpstart[i] || dlpend[i] || tlpstart[i]) begin
                err_n = 1'b1;
                cnt   = '0;
                part  = '0;
                st    = dlpstart[i] ? S_COLLECT : S_IDLE;
              end else begin
                for (int j = 0; j < 6; j++) begin
                  if (cnt == 3'(j)) part[8*j +: 8] = lane_byte;
                end
                cnt = cnt + 3'd1;
              end
            end else if (dlpend[i]) begin
              for (int k = 0; k < SLOTS; k++) begin
                if (int'(slot) == k) begin
                  data_n[48*k +: 48] = part;
                  valid_n[k]         = 1'b1;
                end
              end
              if (int'(slot) != SLOTS) slot = slot + 1'b1;
              st   = S_IDLE;
              cnt  = '0;
              part = '0;
            end else begin
              err_n = 1'b1;
              cnt   = '0;
              part  = '0;
              st    = dlpstart[i] ? S_COLLECT : S_IDLE;
            end
          end
          default: begin
            st   = S_IDLE;
            cnt  = '0;
            part = '0;
          end
        endcase
      end
    end
    state_n   = st;
    cnt_n     = cnt;
    partial_n = part;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      partial_q  <= '0;
      dllp_data  <= '0;
      dllp_valid <= '0;
      dllp_err   <= 1'b0;
    end else begin
      state_q    <= state_n;
      cnt_q      <= cnt_n;
      partial_q  <= partial_n;
      dllp_data  <= data_n;
      dllp_valid <= valid_n;
      dllp_err   <= err_n;
    end
  end

endmodule

// File: tb/tb_dllp_extractor.sv
// Directed and randomized bench for dllp_extractor; a token-level queue model
// predicts slots, valids and error pulses for every beat.
module tb_dllp_extractor;

  logic         clk = 1'b0;
  logic         rst;
  logic [511:0] din;
  logic [63:0]  vd, ds, de, ts;
  logic [383:0] dllp_data;
  logic [7:0]   dllp_valid;
  logic         dllp_err;

  int total = 0;
  int bad   = 0;

  bit            m_active;
  byte unsigned  m_q[$];
  logic [383:0]  exp_data;
  logic [7:0]    exp_valid;
  logic          exp_err;
  logic [9:0]    tok_q[$];

  dllp_extractor dut (
    .clk(clk), .rst(rst), .Data_in(din), .valid_d(vd), .dlpstart(ds),
    .dlpend(de), .tlpstart(ts), .dllp_data(dllp_data),
    .dllp_valid(dllp_valid), .dllp_err(dllp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [383:0] obs, input logic [383:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_beat();
    din = '0; vd = '1; ds = '0; de = '0; ts = '0;
  endtask

  task automatic set_b(input int i, input logic [7:0] b);
    din[8*i +: 8] = b;
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_q.delete();
  endtask

  // Reference: a DLLP is SDP, exactly six plain bytes, END over the valid lanes.
  task automatic model_beat();
    byte unsigned b;
    logic [47:0]  w;
    int           n;
    exp_data = '0; exp_valid = '0; exp_err = 1'b0; n = 0;
    for (int i = 0; i < 64; i++) begin
      if (vd[i]) begin
        b = din[8*i +: 8];
        if (!m_active) begin
          if (ds[i]) begin m_active = 1'b1; m_q.delete(); end
          else if (de[i]) exp_err = 1'b1;
        end else if (m_q.size() < 6) begin
          if (ds[i] || de[i] || ts[i]) begin
            exp_err = 1'b1; m_q.delete(); m_active = ds[i];
          end else m_q.push_back(b);
        end else if (de[i]) begin
          w = '0;
          for (int j = 0; j < 6; j++) w[8*j +: 8] = m_q[j];
          exp_data[48*n +: 48] = w;
          exp_valid[n] = 1'b1;
          n++;
          m_active = 1'b0; m_q.delete();
        end else begin
          exp_err = 1'b1; m_q.delete(); m_active = ds[i];
        end
      end
    end
  endtask

  task automatic beat(input string tag);
    model_beat();
    @(posedge clk); #1;
    chk({tag, ".data"},  dllp_data,  exp_data);
    chk({tag, ".valid"}, dllp_valid, exp_valid);
    chk({tag, ".err"},   dllp_err,   exp_err);
  endtask

  task automatic push_tok(input logic [1:0] kind, input logic [7:0] b);
    tok_q.push_back({kind, b});
  endtask

  task automatic refill();
    int r, n;
    for (int f = 0; f < int'($urandom_range(0, 2)); f++) push_tok(2'd0, 8'($urandom));
    r = $urandom_range(0, 9);
    if (r < 7) begin
      push_tok(2'd1, 8'($urandom));
      for (int j = 0; j < 6; j++) push_tok(2'd0, 8'($urandom));
      push_tok(2'd2, 8'($urandom));
    end else if (r < 8) begin
      push_tok(2'd3, 8'($urandom));
      for (int j = 0; j < int'($urandom_range(0, 4)); j++) push_tok(2'd0, 8'($urandom));
    end else begin
      n = $urandom_range(0, 7);
      push_tok(2'd1, 8'($urandom));
      for (int j = 0; j < n; j++) push_tok(2'd0, 8'($urandom));
      push_tok(2'($urandom_range(1, 3)), 8'($urandom));
    end
  endtask

  task automatic rand_beat();
    logic [9:0] t;
    clear_beat();
    if ($urandom_range(0, 19) == 0) begin
      vd = '0;
      ds = {$urandom, $urandom}; de = {$urandom, $urandom}; ts = {$urandom, $urandom};
      for (int i = 0; i < 64; i++) set_b(i, 8'($urandom));
    end else begin
      for (int i = 0; i < 64; i++) begin
        if ($urandom_range(0, 9) == 0) begin
          vd[i] = 1'b0;
          ds[i] = 1'($urandom); de[i] = 1'($urandom); ts[i] = 1'($urandom);
          set_b(i, 8'($urandom));
        end else begin
          if (tok_q.size() == 0) refill();
          t = tok_q.pop_front();
          set_b(i, t[7:0]);
          ds[i] = (t[9:8] == 2'd1);
          de[i] = (t[9:8] == 2'd2);
          ts[i] = (t[9:8] == 2'd3);
        end
      end
    end
    beat("rand");
  endtask

  initial begin
    rst = 1'b1;
    clear_beat(); vd = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset.data",  dllp_data,  384'd0);
    chk("reset.valid", dllp_valid, 8'h00);
    chk("reset.err",   dllp_err,   1'b0);
    rst = 1'b0;

    // aligned single DLLP
    clear_beat();
    ds[0] = 1'b1;
    for (int j = 1; j <= 6; j++) set_b(j, 8'(j));
    de[7] = 1'b1;
    beat("aligned");
    chk("aligned.slot0", dllp_data[47:0], 48'h060504030201);
    chk("aligned.v",     dllp_valid,      8'h01);

    // eight back-to-back DLLPs
    clear_beat();
    for (int k = 0; k < 8; k++) begin
      ds[8*k] = 1'b1;
      for (int j = 1; j <= 6; j++) set_b(8*k + j, 8'(k));
      de[8*k + 7] = 1'b1;
    end
    beat("eight");
    chk("eight.v",     dllp_valid,         8'hFF);
    chk("eight.slot7", dllp_data[383:336], 48'h070707070707);
    chk("eight.slot3", dllp_data[191:144], 48'h030303030303);

    // straddle across a beat boundary
    clear_beat();
    ds[60] = 1'b1; set_b(61, 8'h11); set_b(62, 8'h12); set_b(63, 8'h13);
    beat("strad1");
    chk("strad1.v", dllp_valid, 8'h00);
    clear_beat();
    set_b(0, 8'h14); set_b(1, 8'h15); set_b(2, 8'h16); de[3] = 1'b1;
    beat("strad2");
    chk("strad2.slot0", dllp_data[47:0], 48'h161514131211);

    // invalid-lane gap inside a DLLP
    clear_beat();
    ds[0] = 1'b1; vd[3] = 1'b0; de[3] = 1'b1; set_b(3, 8'hEE);
    set_b(1, 8'h01); set_b(2, 8'h02); set_b(4, 8'h03);
    set_b(5, 8'h04); set_b(6, 8'h05); set_b(7, 8'h06); de[8] = 1'b1;
    beat("gap");
    chk("gap.slot0", dllp_data[47:0], 48'h060504030201);

    // framing: early END
    clear_beat();
    ds[0] = 1'b1;
    for (int j = 1; j <= 4; j++) set_b(j, 8'(j));
    de[5] = 1'b1;
    beat("frm1");
    chk("frm1.v",   dllp_valid, 8'h00);
    chk("frm1.err", dllp_err,   1'b1);

    // framing: STP inside DLLP, followed by a good DLLP in the same beat
    clear_beat();
    ds[0] = 1'b1; set_b(1, 8'hA1); set_b(2, 8'hA2); set_b(3, 8'hA3); ts[4] = 1'b1;
    ds[16] = 1'b1;
    for (int j = 1; j <= 6; j++) set_b(16 + j, 8'(8'h30 + j));
    de[23] = 1'b1;
    beat("frm2");
    chk("frm2.err",   dllp_err,        1'b1);
    chk("frm2.v",     dllp_valid,      8'h01);
    chk("frm2.slot0", dllp_data[47:0], 48'h363534333231);

    // reset in the middle of a DLLP
    clear_beat();
    ds[60] = 1'b1; set_b(61, 8'h21); set_b(62, 8'h22); set_b(63, 8'h23);
    beat("rstpre");
    clear_beat(); vd = '0;
    rst = 1'b1;
    #2;
    chk("rstmid.data",  dllp_data,  384'd0);
    chk("rstmid.valid", dllp_valid, 8'h00);
    chk("rstmid.err",   dllp_err,   1'b0);
    @(posedge clk); #1;
    chk("rsthold.valid", dllp_valid, 8'h00);
    rst = 1'b0;
    model_reset();
    clear_beat();
    set_b(0, 8'h24); set_b(1, 8'h25); set_b(2, 8'h26); de[3] = 1'b1;
    beat("rstpost");
    chk("rstpost.v",   dllp_valid, 8'h00);
    chk("rstpost.err", dllp_err,   1'b1);

    // randomized traffic against the model
    for (int n = 0; n < 300; n++) rand_beat();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
